// File: rtl/hw2_div_pkg.sv
// Shared types and widths for the HW2 iterative divider.
// Optional feature macro: HW2_DIV_ZERO_BYPASS_EN (zero divisor skips the CALC phase).
package hw2_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DW = 16;
  localparam int VW = 8;
  localparam int CW = $clog2(DW);

  localparam logic [DW-1:0] ZERO_QUOT = {DW{1'b1}};

endpackage

// File: rtl/hw2_iter_div_if.sv
// Request/result bundle for the HW2 iterative divider.
// Both channels use valid/ready: a transfer happens on a rising edge where valid and ready are both high;
// the sender keeps valid and its data stable until that edge.
interface hw2_iter_div_if;
  import hw2_div_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_zero;

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_zero
  );

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_zero
  );

endinterface

// File: rtl/hw2_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit and
// subtract the divisor when the trial value allows it.
module hw2_div_step
  import hw2_div_pkg::*;
(
  input  logic [VW-1:0] rem,
  input  logic          next_bit,
  input  logic [VW-1:0] divisor,
  output logic [VW-1:0] rem_next,
  output logic          q_bit
);

  logic [VW:0] trial;
  logic [VW:0] diff;

  always_comb begin
    trial    = {rem, next_bit};
    diff     = trial - {1'b0, divisor};
    q_bit    = (trial >= {1'b0, divisor});
    // rem < divisor on entry, so the kept value always fits in VW bits
    rem_next = VW'(q_bit ? diff : trial);
  end

endmodule

// File: rtl/hw2_iter_div.sv
// Iterative unsigned divider, one quotient bit per cycle, MSB first.
// Optional feature macro: HW2_DIV_ZERO_BYPASS_EN (zero divisor goes straight to DONE).
module hw2_iter_div
  import hw2_div_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  hw2_iter_div_if.slave    bus,
  output state_t           fsm_state
);

  state_t        state;
  logic [DW-1:0] work_r;
  logic [VW-1:0] divisor_r;
  logic [VW-1:0] rem_r;
  logic [CW-1:0] cnt;
  logic          zero_r;
  logic          in_ready_r;
  logic          out_valid_r;
  logic [DW-1:0] quotient_r;
  logic [VW-1:0] remainder_r;
  logic          div_zero_r;

  logic [VW-1:0] rem_next;
  logic          q_bit;

  // work_r shifts dividend bits out at the top and quotient bits in at the bottom
  hw2_div_step u_step (
    .rem      (rem_r),
    .next_bit (work_r[DW-1]),
    .divisor  (divisor_r),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      work_r      <= '0;
      divisor_r   <= '0;
      rem_r       <= '0;
      cnt         <= '0;
      zero_r      <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      quotient_r  <= '0;
      remainder_r <= '0;
      div_zero_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            work_r     <= bus.dividend;
            divisor_r  <= bus.divisor;
            rem_r      <= '0;
            zero_r     <= (bus.divisor == '0);
            in_ready_r <= 1'b0;
`ifdef HW2_DIV_ZERO_BYPASS_EN
            if (bus.divisor == '0) begin
              state       <= DONE;
              out_valid_r <= 1'b1;
              quotient_r  <= ZERO_QUOT;
              remainder_r <= '0;
              div_zero_r  <= 1'b1;
            end else begin
              cnt   <= CW'(DW - 1);
              state <= CALC;
            end
`else
            cnt   <= CW'(DW - 1);
            state <= CALC;
`endif
          end
        end
        CALC: begin
          work_r <= {work_r[DW-2:0], q_bit};
          rem_r  <= rem_next;
          cnt    <= cnt - 1'b1;
          if (cnt == '0) begin
            state       <= DONE;
            out_valid_r <= 1'b1;
            if (zero_r) begin
              quotient_r  <= ZERO_QUOT;
              remainder_r <= '0;
              div_zero_r  <= 1'b1;
            end else begin
              quotient_r  <= {work_r[DW-2:0], q_bit};
              remainder_r <= rem_next;
              div_zero_r  <= 1'b0;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.quotient  = quotient_r;
  assign bus.remainder = remainder_r;
  assign bus.div_zero  = div_zero_r;
  assign fsm_state     = state;

endmodule

// File: tb/tb_hw2_iter_div.sv
// Directed, table-driven bench for hw2_iter_div plus hand-written stall, ignore and reset sequences.
module tb_hw2_iter_div;
  import hw2_div_pkg::*;

`ifdef HW2_DIV_ZERO_BYPASS_EN
  // out_valid is already up right after the accept edge
  localparam int ZLAT = 0;
`else
  localparam int ZLAT = 16;
`endif
  localparam int LAT = 16;

  logic   clk;
  logic   reset;
  state_t fsm_state;
  int     checks;
  int     errors;

  hw2_iter_div_if bus ();

  hw2_iter_div dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .fsm_state (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] dd;
    logic [7:0]  dv;
    logic [15:0] q;
    logic [7:0]  r;
    logic        z;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // drive one request and return once the accept edge has passed
  task automatic start(input logic [15:0] dd, input logic [7:0] dv);
    @(negedge clk);
    check("accept_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.dividend = dd;
    bus.divisor  = dv;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.dividend = 16'($urandom);
    bus.divisor  = 8'($urandom);
    check("busy_not_ready", 32'(bus.in_ready), 32'd0);
  endtask

  // count edges after accept until out_valid, bounded
  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic handoff();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("handoff_valid_low", 32'(bus.out_valid), 32'd0);
    check("handoff_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic check_result(input string tag, input logic [15:0] q, input logic [7:0] r, input logic z);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_quot"}, 32'(bus.quotient), 32'(q));
    check({tag, "_rem"}, 32'(bus.remainder), 32'(r));
    check({tag, "_zero"}, 32'(bus.div_zero), 32'(z));
  endtask

  initial begin
    int lat;
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b0;

    vecs[0] = '{16'd1000,   8'd10,  16'd100,   8'd0,  1'b0};
    vecs[1] = '{16'd200,    8'd7,   16'd28,    8'd4,  1'b0};
    vecs[2] = '{16'd65535,  8'd255, 16'd257,   8'd0,  1'b0};
    vecs[3] = '{16'd65535,  8'd1,   16'd65535, 8'd0,  1'b0};
    vecs[4] = '{16'd5,      8'd200, 16'd0,     8'd5,  1'b0};
    vecs[5] = '{16'h1234,   8'd0,   16'hFFFF,  8'd0,  1'b1};
    vecs[6] = '{16'd0,      8'd5,   16'd0,     8'd0,  1'b0};
    vecs[7] = '{16'd255,    8'd16,  16'd15,    8'd15, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_quot", 32'(bus.quotient), 32'd0);
    check("rst_rem", 32'(bus.remainder), 32'd0);
    check("rst_zero", 32'(bus.div_zero), 32'd0);
    check("rst_state", 32'(fsm_state), 32'(IDLE));
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      start(vecs[i].dd, vecs[i].dv);
      wait_done(lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), (vecs[i].dv == 8'd0) ? 32'(ZLAT) : 32'(LAT));
      check_result($sformatf("vec%0d", i), vecs[i].q, vecs[i].r, vecs[i].z);
      handoff();
      check($sformatf("vec%0d_hold_idle", i), 32'(bus.quotient), 32'(vecs[i].q));
    end

    // stalled consumer: result must hold
    start(16'd300, 8'd3);
    wait_done(lat);
    check("stall_latency", 32'(lat), 32'(LAT));
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check_result($sformatf("stall%0d", k), 16'd100, 8'd0, 1'b0);
      check($sformatf("stall%0d_not_ready", k), 32'(bus.in_ready), 32'd0);
    end
    handoff();

    // new requests during CALC must be ignored
    start(16'd1000, 8'd10);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      bus.in_valid = k[0];
      bus.dividend = 16'd7;
      bus.divisor  = 8'd3;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    wait_done(lat);
    check("ignore_latency", 32'(lat + 10), 32'(LAT));
    check_result("ignore", 16'd100, 8'd0, 1'b0);
    handoff();

    // asynchronous reset in the middle of CALC
    start(16'd4000, 8'd9);
    repeat (7) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    check("midrst_quot", 32'(bus.quotient), 32'd0);
    check("midrst_rem", 32'(bus.remainder), 32'd0);
    check("midrst_state", 32'(fsm_state), 32'(IDLE));
    @(negedge clk);
    reset = 1'b0;
    start(16'd4000, 8'd9);
    wait_done(lat);
    check("after_rst_latency", 32'(lat), 32'(LAT));
    check_result("after_rst", 16'd444, 8'd4, 1'b0);
    handoff();

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
